// File: rtl/dec_scan_nto2n_if.sv
// Bus bundle for dec_scan_nto2n.
//   master (driver side): en, mode, a, blank out; y, idx, tick in
//   slave  (decoder side): the mirror image
// Signals:
//   en     1      decode/scan enable; 0 blanks y and holds state
//   mode   1      0 = direct decode of a, 1 = auto-scan
//   a      SEL_W  direct-mode select index
//   blank  OUT_N  per-output force-inactive mask
//   y      OUT_N  registered one-hot output (polarity per ACTIVE_LOW)
//   idx    SEL_W  registered currently selected index
//   tick   1      one-cycle pulse on each scan step
interface dec_scan_nto2n_if #(
    parameter int SEL_W = 3,
    parameter int OUT_N = 8
);
    logic             en;
    logic             mode;
    logic [SEL_W-1:0] a;
    logic [OUT_N-1:0] blank;
    logic [OUT_N-1:0] y;
    logic [SEL_W-1:0] idx;
    logic             tick;

    modport master (
        output en, mode, a, blank,
        input  y, idx, tick
    );

    modport slave (
        input  en, mode, a, blank,
        output y, idx, tick
    );
endinterface

// File: rtl/dec_scan_nto2n.sv
// Registered SEL_W-to-OUT_N one-hot decoder with enable, per-output
// blanking and an auto-scan mode driven by a prescaled step counter.
// Ports:
//   clk   clock, all state changes on the rising edge
//   rst   synchronous active-high reset, highest priority
//   bus   dec_scan_nto2n_if.slave: en, mode, a, blank in; y, idx, tick out
module dec_scan_nto2n #(
    parameter int SEL_W      = 3,
    parameter int OUT_N      = 8,
    parameter int PRESCALE   = 4,
    parameter bit ACTIVE_LOW = 1'b0
) (
    input  logic                   clk,
    input  logic                   rst,
    dec_scan_nto2n_if.slave        bus
);
    localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);
    localparam logic [SEL_W-1:0] IDX_LAST = SEL_W'(OUT_N - 1);
    localparam logic [OUT_N-1:0] Y_IDLE   = ACTIVE_LOW ? {OUT_N{1'b1}} : {OUT_N{1'b0}};

    logic [SEL_W-1:0] idx_q, idx_d;
    logic [PRE_W-1:0] pre_q, pre_d;
    logic             mode_q, mode_d;
    logic [OUT_N-1:0] y_q, y_d;
    logic             tick_q, tick_d;
    logic [OUT_N-1:0] dec;

    // Every enabled branch drives y with onehot(new idx), so the decoder
    // only needs to look at idx_d. An idx >= OUT_N matches no bit.
    generate
        for (genvar gi = 0; gi < OUT_N; gi++) begin : g_dec
            assign dec[gi] = (idx_d == SEL_W'(gi)) && !bus.blank[gi];
        end
    endgenerate

    always_comb begin
        idx_d  = idx_q;
        pre_d  = pre_q;
        mode_d = mode_q;
        tick_d = 1'b0;
        if (bus.en) begin
            mode_d = bus.mode;
            if (!bus.mode) begin
                idx_d = bus.a;
                pre_d = '0;
            end else if (!mode_q) begin
                // Scan entry always restarts at index 0.
                idx_d = '0;
                pre_d = '0;
            end else if (pre_q == PRE_LAST) begin
                pre_d  = '0;
                tick_d = 1'b1;
                idx_d  = (idx_q == IDX_LAST) ? '0 : idx_q + SEL_W'(1);
            end else begin
                pre_d = pre_q + PRE_W'(1);
            end
        end
    end

    // Polarity inversion goes after blanking so blanked bits read inactive.
    always_comb begin
        y_d = Y_IDLE;
        if (bus.en) begin
            y_d = ACTIVE_LOW ? ~dec : dec;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q  <= '0;
            pre_q  <= '0;
            mode_q <= 1'b0;
            y_q    <= Y_IDLE;
            tick_q <= 1'b0;
        end else begin
            idx_q  <= idx_d;
            pre_q  <= pre_d;
            mode_q <= mode_d;
            y_q    <= y_d;
            tick_q <= tick_d;
        end
    end

    assign bus.y    = y_q;
    assign bus.idx  = idx_q;
    assign bus.tick = tick_q;
endmodule

// File: tb/tb_dec_scan_nto2n.sv
module tb_dec_scan_nto2n;
    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       en;
    logic       mode;
    logic [2:0] a;
    logic [7:0] blank;

    int vectors = 0;
    int miscompares = 0;

    // Three configurations: default, partial width with PRESCALE=1, active-low.
    dec_scan_nto2n_if #(.SEL_W(3), .OUT_N(8)) if0 ();
    dec_scan_nto2n_if #(.SEL_W(3), .OUT_N(5)) if1 ();
    dec_scan_nto2n_if #(.SEL_W(3), .OUT_N(8)) if2 ();

    assign if0.en = en;  assign if0.mode = mode;  assign if0.a = a;  assign if0.blank = blank;
    assign if1.en = en;  assign if1.mode = mode;  assign if1.a = a;  assign if1.blank = blank[4:0];
    assign if2.en = en;  assign if2.mode = mode;  assign if2.a = a;  assign if2.blank = blank;

    dec_scan_nto2n #(.SEL_W(3), .OUT_N(8), .PRESCALE(4), .ACTIVE_LOW(1'b0))
        u0 (.clk(clk), .rst(rst), .bus(if0.slave));
    dec_scan_nto2n #(.SEL_W(3), .OUT_N(5), .PRESCALE(1), .ACTIVE_LOW(1'b0))
        u1 (.clk(clk), .rst(rst), .bus(if1.slave));
    dec_scan_nto2n #(.SEL_W(3), .OUT_N(8), .PRESCALE(4), .ACTIVE_LOW(1'b1))
        u2 (.clk(clk), .rst(rst), .bus(if2.slave));

    // Reference model: plain integers per instance.
    int P_N[3]   = '{8, 5, 8};
    int P_PRE[3] = '{4, 1, 4};
    int P_AL[3]  = '{0, 0, 1};
    int m_idx[3];
    int m_pre[3];
    int m_mq[3];
    int m_tick[3];
    logic [7:0] m_y[3];

    logic [7:0] oy[3];
    logic [2:0] oi[3];
    logic       ot[3];

    task automatic model_step();
        for (int k = 0; k < 3; k++) begin
            logic [7:0] v;
            int mask;
            mask = (1 << P_N[k]) - 1;
            v = 8'h00;
            if (rst) begin
                m_idx[k] = 0; m_pre[k] = 0; m_mq[k] = 0; m_tick[k] = 0;
            end else if (!en) begin
                m_tick[k] = 0;
            end else begin
                if (mode == 1'b0) begin
                    m_idx[k] = int'(a); m_pre[k] = 0; m_tick[k] = 0;
                end else if (m_mq[k] == 0) begin
                    m_idx[k] = 0; m_pre[k] = 0; m_tick[k] = 0;
                end else begin
                    m_pre[k] = m_pre[k] + 1;
                    m_tick[k] = 0;
                    if (m_pre[k] == P_PRE[k]) begin
                        m_pre[k] = 0;
                        m_idx[k] = (m_idx[k] + 1) % P_N[k];
                        m_tick[k] = 1;
                    end
                end
                m_mq[k] = int'(mode);
                if (m_idx[k] < P_N[k] && !blank[m_idx[k]]) v = 8'(1 << m_idx[k]);
            end
            if (P_AL[k] != 0) v = ~v & 8'(mask);
            m_y[k] = v;
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
        oy[0] = if0.y;  oy[1] = {3'b000, if1.y};  oy[2] = if2.y;
        oi[0] = if0.idx; oi[1] = if1.idx; oi[2] = if2.idx;
        ot[0] = if0.tick; ot[1] = if1.tick; ot[2] = if2.tick;
    endtask

    task automatic test_reset();
        logic [7:0] ry[3];
        ry[0] = 8'h00; ry[1] = 8'h00; ry[2] = 8'hFF;
        rst = 1; en = 0; mode = 0; a = 0; blank = 0;
        cyc(); cyc();
        for (int k = 0; k < 3; k++) begin
            vectors++;
            if (oy[k] !== ry[k] || oi[k] !== 3'd0 || ot[k] !== 1'b0) begin
                miscompares++;
                $display("FAIL reset[%0d]: y=%h idx=%0d tick=%b, required y=%h idx=0 tick=0", k, oy[k], oi[k], ot[k], ry[k]);
            end
        end
        rst = 0;
    endtask

    task automatic test_direct_sweep();
        en = 1; mode = 0; blank = 0;
        for (int i = 0; i < 8; i++) begin
            logic [7:0] e;
            a = 3'(i);
            cyc();
            e = 8'(1 << i);
            vectors++;
            if (oy[0] !== e || oi[0] !== 3'(i) || ot[0] !== 1'b0) begin
                miscompares++;
                $display("FAIL direct a=%0d: y=%h idx=%0d tick=%b, required y=%h idx=%0d tick=0", i, oy[0], oi[0], ot[0], e, i);
            end
            vectors++;
            if (oy[2] !== ~e) begin
                miscompares++;
                $display("FAIL direct_al a=%0d: y=%h, required %h", i, oy[2], ~e);
            end
        end
    endtask

    task automatic test_blank_disable();
        en = 1; mode = 0; a = 3'd5; blank = 8'h20;
        cyc();
        vectors++;
        if (oy[0] !== 8'h00 || oi[0] !== 3'd5) begin
            miscompares++;
            $display("FAIL blanked: y=%h idx=%0d, required y=00 idx=5", oy[0], oi[0]);
        end
        blank = 8'h00;
        cyc();
        vectors++;
        if (oy[0] !== 8'h20) begin
            miscompares++;
            $display("FAIL unblanked: y=%h, required 20", oy[0]);
        end
        en = 0;
        cyc();
        vectors++;
        if (oy[0] !== 8'h00 || oi[0] !== 3'd5) begin
            miscompares++;
            $display("FAIL disabled: y=%h idx=%0d, required y=00 idx=5", oy[0], oi[0]);
        end
        en = 1;
    endtask

    task automatic test_scan_run();
        int ticks;
        en = 1; mode = 0; a = 0; blank = 0;
        cyc();
        mode = 1;
        cyc();
        vectors++;
        if (oy[0] !== 8'h01 || oi[0] !== 3'd0 || ot[0] !== 1'b0) begin
            miscompares++;
            $display("FAIL scan_entry: y=%h idx=%0d tick=%b, required y=01 idx=0 tick=0", oy[0], oi[0], ot[0]);
        end
        ticks = 0;
        for (int c = 1; c <= 32; c++) begin
            int ei;
            logic et;
            cyc();
            ei = (c / 4) % 8;
            et = (c % 4 == 0);
            if (ot[0] === 1'b1) ticks++;
            vectors++;
            if (oi[0] !== 3'(ei) || ot[0] !== et || oy[0] !== 8'(1 << ei)) begin
                miscompares++;
                $display("FAIL scan c=%0d: idx=%0d tick=%b y=%h, required idx=%0d tick=%b y=%h", c, oi[0], ot[0], oy[0], ei, et, 8'(1 << ei));
            end
        end
        vectors++;
        if (ticks != 8) begin
            miscompares++;
            $display("FAIL scan_period: ticks=%0d in 32 cycles, required 8", ticks);
        end
    endtask

    task automatic test_partial();
        en = 1; mode = 0; a = 0; blank = 0;
        cyc();
        mode = 1;
        cyc();
        vectors++;
        if (oi[1] !== 3'd0 || ot[1] !== 1'b0 || oy[1] !== 8'h01) begin
            miscompares++;
            $display("FAIL partial_entry: idx=%0d tick=%b y=%h, required idx=0 tick=0 y=01", oi[1], ot[1], oy[1]);
        end
        for (int c = 1; c <= 10; c++) begin
            cyc();
            vectors++;
            if (oi[1] !== 3'(c % 5) || ot[1] !== 1'b1 || oy[1] !== 8'(1 << (c % 5))) begin
                miscompares++;
                $display("FAIL partial c=%0d: idx=%0d tick=%b y=%h, required idx=%0d tick=1", c, oi[1], ot[1], oy[1], c % 5);
            end
        end
        mode = 0; a = 3'd6;
        cyc();
        vectors++;
        if (oy[1] !== 8'h00 || oi[1] !== 3'd6) begin
            miscompares++;
            $display("FAIL partial_oob: y=%h idx=%0d, required y=00 idx=6", oy[1], oi[1]);
        end
    endtask

    task automatic test_pause_reset();
        bit found;
        bit ticked;
        en = 1; mode = 0; a = 0; blank = 0;
        cyc();
        mode = 1;
        found = 0;
        for (int c = 0; c < 64 && !found; c++) begin
            cyc();
            if (m_idx[0] == 3 && m_pre[0] == 2) found = 1;
        end
        vectors++;
        if (!found) begin
            miscompares++;
            $display("FAIL pause_reach: idx=%0d, required idx=3 within 64 cycles", oi[0]);
        end
        en = 0;
        for (int c = 0; c < 5; c++) begin
            cyc();
            vectors++;
            if (oy[0] !== 8'h00 || oi[0] !== 3'd3 || ot[0] !== 1'b0) begin
                miscompares++;
                $display("FAIL paused c=%0d: y=%h idx=%0d tick=%b, required y=00 idx=3 tick=0", c, oy[0], oi[0], ot[0]);
            end
        end
        en = 1;
        cyc();
        vectors++;
        if (oy[0] !== 8'h08 || oi[0] !== 3'd3) begin
            miscompares++;
            $display("FAIL resume: y=%h idx=%0d, required y=08 idx=3", oy[0], oi[0]);
        end
        ticked = 0;
        for (int c = 0; c < 4 && !ticked; c++) begin
            cyc();
            if (ot[0] === 1'b1) ticked = 1;
        end
        vectors++;
        if (!ticked || oi[0] !== 3'd4 || oy[0] !== 8'h10) begin
            miscompares++;
            $display("FAIL resume_step: ticked=%b idx=%0d y=%h, required tick within 4 cycles idx=4 y=10", ticked, oi[0], oy[0]);
        end
        rst = 1;
        cyc();
        vectors++;
        if (oy[0] !== 8'h00 || oi[0] !== 3'd0 || ot[0] !== 1'b0 || oy[2] !== 8'hFF) begin
            miscompares++;
            $display("FAIL mid_reset: y=%h idx=%0d tick=%b y_al=%h, required y=00 idx=0 tick=0 y_al=FF", oy[0], oi[0], ot[0], oy[2]);
        end
        rst = 0;
    endtask

    task automatic test_polarity();
        rst = 1;
        cyc();
        vectors++;
        if (oy[2] !== 8'hFF) begin
            miscompares++;
            $display("FAIL pol_reset: y=%h, required FF", oy[2]);
        end
        rst = 0; en = 1; mode = 0; a = 3'd2; blank = 0;
        cyc();
        vectors++;
        if (oy[2] !== 8'hFB || oi[2] !== 3'd2) begin
            miscompares++;
            $display("FAIL pol_decode: y=%h idx=%0d, required y=FB idx=2", oy[2], oi[2]);
        end
        en = 0;
        cyc();
        vectors++;
        if (oy[2] !== 8'hFF) begin
            miscompares++;
            $display("FAIL pol_disable: y=%h, required FF", oy[2]);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            rst   = ($urandom_range(0, 59) == 0);
            en    = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 19) == 0) mode = ~mode;
            a     = 3'($urandom);
            blank = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
            cyc();
            for (int k = 0; k < 3; k++) begin
                vectors++;
                if (oy[k] !== m_y[k] || oi[k] !== 3'(m_idx[k]) || ot[k] !== 1'(m_tick[k])) begin
                    miscompares++;
                    $display("FAIL random c=%0d u%0d: y=%h idx=%0d tick=%b, required y=%h idx=%0d tick=%0d",
                             c, k, oy[k], oi[k], ot[k], m_y[k], m_idx[k], m_tick[k]);
                end
            end
        end
        rst = 0;
    endtask

    initial begin
        rst = 1; en = 0; mode = 0; a = 0; blank = 0;
        for (int k = 0; k < 3; k++) begin
            m_idx[k] = 0; m_pre[k] = 0; m_mq[k] = 0; m_tick[k] = 0; m_y[k] = 8'h00;
        end
        test_reset();
        test_direct_sweep();
        test_blank_disable();
        test_scan_run();
        test_partial();
        test_pause_reset();
        test_polarity();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
